// File: rtl/mode_uart_command_decoder.sv
// rtl/mode_uart_command_decoder.sv - 8N1 UART receiver decoding newline-terminated mode names into a 3-bit mode request
// Optional build macro: MODE_CMD_CASE_FOLD_EN (fold lowercase ASCII to uppercase before storing)
module mode_uart_command_decoder #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD_RATE   = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rx,
  output logic [2:0] mode_code,
  output logic       mode_valid,
  output logic       cmd_error,
  output logic       rx_busy
);

  localparam int BIT_CYCLES = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CW = $clog2(2 * BIT_CYCLES + 1);
  localparam logic [CW-1:0] BIT_LAST   = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] HALF_LAST  = CW'(BIT_CYCLES / 2 - 1);
  localparam logic [CW-1:0] GUARD_LAST = CW'(2 * BIT_CYCLES - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]    sync;
  logic          line;
  logic [CW-1:0] guard_cnt;
  logic          guard_done;
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          stop_sample;
  logic          byte_stb;
  logic          frame_err;
  logic [7:0]    store_byte;
  logic [55:0]   line_buf;
  logic [3:0]    len;
  logic          line_bad;
  logic          hit;
  logic [2:0]    hit_code;

  assign line = sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= 2'b11;
    else        sync <= {sync[0], uart_rx};
  end

  // Ignore start bits until the line has idled long enough to be between frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      guard_cnt  <= '0;
      guard_done <= 1'b0;
    end else if (!guard_done) begin
      if (!line)                        guard_cnt  <= '0;
      else if (guard_cnt == GUARD_LAST) guard_done <= 1'b1;
      else                              guard_cnt  <= guard_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (guard_done && !line) begin
            state <= S_START;
            cnt   <= HALF_LAST;
          end
        end
        S_START: begin
          if (cnt == '0) begin
            if (!line) begin
              state   <= S_DATA;
              bit_idx <= '0;
              cnt     <= BIT_LAST;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_DATA: begin
          if (cnt == '0) begin
            shift <= {line, shift[7:1]};
            cnt   <= BIT_LAST;
            if (bit_idx == 3'd7) state   <= S_STOP;
            else                 bit_idx <= bit_idx + 3'd1;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          if (cnt == '0) state <= S_IDLE;
          else           cnt   <= cnt - CW'(1);
        end
      endcase
    end
  end

  assign stop_sample = (state == S_STOP) && (cnt == '0);
  assign byte_stb    = stop_sample && line;
  assign frame_err   = stop_sample && !line;
  assign rx_busy     = (state != S_IDLE) || !guard_done;

  always_comb begin
    store_byte = shift;
`ifdef MODE_CMD_CASE_FOLD_EN
    if (shift >= 8'h61 && shift <= 8'h7A) store_byte = shift - 8'h20;
`endif
  end

  // line_buf is a byte shift register: the last stored byte sits in [7:0].
  always_comb begin
    hit      = 1'b0;
    hit_code = 3'd0;
    case (len)
      4'd7: if (line_buf == "DEFAULT") begin hit = 1'b1; hit_code = 3'd0; end
      4'd5: begin
        if (line_buf[39:0] == "STORE") begin hit = 1'b1; hit_code = 3'd1; end
        if (line_buf[39:0] == "SETUP") begin hit = 1'b1; hit_code = 3'd5; end
      end
      4'd4: begin
        if (line_buf[31:0] == "SHOW") begin hit = 1'b1; hit_code = 3'd3; end
        if (line_buf[31:0] == "CALC") begin hit = 1'b1; hit_code = 3'd4; end
      end
      4'd3: if (line_buf[23:0] == "GEN") begin hit = 1'b1; hit_code = 3'd2; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_buf   <= '0;
      len        <= '0;
      line_bad   <= 1'b0;
      mode_code  <= 3'd0;
      mode_valid <= 1'b0;
      cmd_error  <= 1'b0;
    end else begin
      mode_valid <= 1'b0;
      cmd_error  <= 1'b0;
      if (frame_err) begin
        line_bad <= 1'b1;
      end else if (byte_stb) begin
        if (shift == 8'h0D) begin
          line_bad <= line_bad;
        end else if (shift == 8'h0A) begin
          if (len == 4'd0 && !line_bad) begin
            mode_valid <= 1'b0;
          end else if (!line_bad && hit) begin
            mode_code  <= hit_code;
            mode_valid <= 1'b1;
          end else begin
            cmd_error <= 1'b1;
          end
          len      <= '0;
          line_bad <= 1'b0;
        end else if (len < 4'd7) begin
          line_buf <= {line_buf[47:0], store_byte};
          len      <= len + 4'd1;
        end else begin
          line_bad <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mode_uart_command_decoder.sv
// tb/tb_mode_uart_command_decoder.sv - scoreboard bench with a string-level line model for mode_uart_command_decoder
module tb_mode_uart_command_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       uart_rx = 1'b1;
  logic [2:0] mode_code;
  logic       mode_valid;
  logic       cmd_error;
  logic       rx_busy;

  mode_uart_command_decoder #(
    .CLK_FREQ_HZ(1_000_000),
    .BAUD_RATE  (100_000)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .uart_rx   (uart_rx),
    .mode_code (mode_code),
    .mode_valid(mode_valid),
    .cmd_error (cmd_error),
    .rx_busy   (rx_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit       err;
    bit [2:0] code;
    int       at;
  } exp_t;

  exp_t     exp_q[$];
  byte      line_q[$];
  bit       line_bad = 1'b0;
  bit [2:0] model_code = 3'd0;
  string    names[6] = '{"DEFAULT", "STORE", "GEN", "SHOW", "CALC", "SETUP"};

  task automatic check(string name, int actual, int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic bit line_is(string nm);
    if (nm.len() != line_q.size()) return 1'b0;
    for (int i = 0; i < nm.len(); i++)
      if (nm[i] != line_q[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Reference: a line is text up to '\n'; pulses land 98 cycles after the pin start edge of '\n'.
  task automatic model_byte(byte b, bit framing, int start_cyc);
    int found;
    byte c;
    if (framing) begin
      line_bad = 1'b1;
    end else if (b == 8'h0D) begin
      line_bad = line_bad;
    end else if (b == 8'h0A) begin
      if (line_q.size() != 0 || line_bad) begin
        found = -1;
        for (int i = 0; i < 6; i++)
          if (line_is(names[i])) found = i;
        if (!line_bad && found >= 0) begin
          model_code = 3'(found);
          exp_q.push_back('{1'b0, model_code, start_cyc + 98});
        end else begin
          exp_q.push_back('{1'b1, model_code, start_cyc + 98});
        end
      end
      line_q.delete();
      line_bad = 1'b0;
    end else begin
      c = b;
`ifdef MODE_CMD_CASE_FOLD_EN
      if (c >= 8'h61 && c <= 8'h7A) c = c - 8'h20;
`endif
      if (line_q.size() < 7) line_q.push_back(c);
      else line_bad = 1'b1;
    end
  endtask

  // Caller is #1 after a rising edge; each bit is held for 10 clocks.
  task automatic send_frame(logic [7:0] b, bit stop_bit, int gap, bit model_en);
    int n;
    n = cyc;
    uart_rx = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (10) @(posedge clk);
      #1;
    end
    uart_rx = stop_bit;
    if (model_en) model_byte(byte'(b), !stop_bit, n);
    repeat (10) @(posedge clk);
    #1;
    uart_rx = 1'b1;
    repeat (gap) @(posedge clk);
    #1;
  endtask

  task automatic send_str(string s, int gap, bit model_en);
    for (int i = 0; i < s.len(); i++) send_frame(s[i], 1'b1, gap, model_en);
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (mode_valid || cmd_error)) begin
      check("pulse_exclusive", int'(mode_valid && cmd_error), 0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: got valid=%0d error=%0d, expected no pulse (cycle %0d)",
                 mode_valid, cmd_error, cyc);
      end else begin
        e = exp_q.pop_front();
        check("pulse_is_error", int'(cmd_error), int'(e.err));
        check("mode_code", int'(mode_code), int'(e.code));
        check("pulse_cycle", cyc, e.at);
      end
    end
  end

  initial begin
    int    kind;
    int    ln;
    string s;
    byte   ch;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_mode_code", int'(mode_code), 0);
    check("reset_mode_valid", int'(mode_valid), 0);
    check("reset_cmd_error", int'(cmd_error), 0);
    check("reset_rx_busy", int'(rx_busy), 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("guard_busy", int'(rx_busy), 1);
    idle(30);
    check("guard_released", int'(rx_busy), 0);

    send_str("SETUP\n", 2, 1'b1);
    for (int i = 0; i < 5; i++) send_str({names[i], "\n"}, 3, 1'b1);
    send_str("GEN\r\n", 1, 1'b1);

    send_str("GENX\n", 1, 1'b1);
    send_str("ABCDEFGHIJ\n", 1, 1'b1);
    send_str("GE\n", 1, 1'b1);

    send_str("\n", 0, 1'b1);
    send_str("SHOW\n", 0, 1'b1);

    send_str("CA", 0, 1'b1);
    send_frame(8'h41, 1'b0, 20, 1'b1);
    send_str("LC\n", 2, 1'b1);
    send_str("CALC\n", 2, 1'b1);

    uart_rx = 1'b0;
    idle(3);
    uart_rx = 1'b1;
    idle(20);
    send_str("DEFAULT\n", 2, 1'b1);
    send_str("SETUP\n", 2, 1'b1);

    fork
      send_str("STORE\n", 0, 1'b0);
      begin
        idle(335);
        rst_n = 1'b0;
        model_code = 3'd0;
        line_q.delete();
        line_bad = 1'b0;
        @(negedge clk);
        check("midreset_mode_code", int'(mode_code), 0);
        check("midreset_rx_busy", int'(rx_busy), 1);
        idle(3);
        rst_n = 1'b1;
      end
    join
    idle(40);
    send_str("GEN\n", 2, 1'b1);

    send_str("calc\n", 2, 1'b1);

    for (int t = 0; t < 40; t++) begin
      kind = int'($urandom_range(0, 9));
      s = "";
      if (kind < 5) begin
        s = names[$urandom_range(0, 5)];
        for (int i = 0; i < s.len(); i++) begin
          ch = s[i];
          if ($urandom_range(0, 5) == 0) ch = ch + 8'h20;
          send_frame(ch, 1'b1, int'($urandom_range(0, 3)), 1'b1);
        end
        if ($urandom_range(0, 3) == 0) send_frame(8'h0D, 1'b1, 0, 1'b1);
      end else begin
        ln = int'($urandom_range(0, 10));
        for (int i = 0; i < ln; i++) begin
          ch = byte'($urandom_range(8'h20, 8'h7E));
          if (kind == 9 && i == 1) send_frame(ch, 1'b0, 20, 1'b1);
          else send_frame(ch, 1'b1, int'($urandom_range(0, 3)), 1'b1);
        end
      end
      send_frame(8'h0A, 1'b1, int'($urandom_range(0, 4)), 1'b1);
    end

    idle(200);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mode_uart_command_decoder.md
# mode_uart_command_decoder

Receive-side counterpart of the mode notifier. It samples an 8N1 UART line, assembles newline-terminated ASCII lines, and decodes the six mode names into a 3-bit mode request. It pulses `mode_valid` for recognised commands and `cmd_error` for malformed ones. It sits between the board UART RX pin and the top-level mode controller, so a host can set the mode with the same strings the notifier prints.

## Interface
- `CLK_FREQ_HZ`, default 100_000_000: board clock frequency.
- `BAUD_RATE`, default 115200: line rate. `BIT_CYCLES = CLK_FREQ_HZ / BAUD_RATE`, using integer division.
- `clk`  input  1  system clock; all logic on the rising edge.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `uart_rx`  input  1  asynchronous serial input; idles high.
- `mode_code`  output  3  last successfully decoded mode. Reset value 0.
- `mode_valid`  output  1  one-cycle pulse when `mode_code` is updated. Reset value 0.
- `cmd_error`  output  1  one-cycle pulse when a non-empty line is rejected. Reset value 0.
- `rx_busy`  output  1  high while the receiver is outside IDLE, or while the reset guard is active. Reset value 1.

## Operation
- Mode codes:
  - DEFAULT=0, STORE=1, GEN=2, SHOW=3, CALC=4, SETUP=5.
  - Codes 6 and 7 are never produced.
- Input conditioning: `uart_rx` passes through a 2-flop synchroniser. Both flops reset to 1.
- Reset guard:
  - After `rst_n` is released, start bits are ignored until the synchronised line has been high for `2*BIT_CYCLES` consecutive cycles.
  - Any low sample restarts the guard count.
  - This discards the tail of a frame that was interrupted by reset.
- Receiver states: IDLE, START, DATA, STOP.
  - IDLE -> START: synchronised line is low while not in the guard. Load counter with `BIT_CYCLES/2 - 1`.
  - START: when the counter expires, sample the line.
    - Low: go to DATA, bit index = 0, counter = `BIT_CYCLES-1`.
    - High: treat as a glitch and return to IDLE.
  - DATA: sample one bit at each counter expiry, LSB first, into the shift register. After bit 7, go to STOP.
  - STOP: sample at counter expiry.
    - High: deliver the byte to the line assembler.
    - Low: flag a framing error; no byte is delivered.
    - In both cases, return to IDLE in the same cycle.
- Line assembler: 7-byte buffer, 4-bit length counter, sticky `line_bad` flag.
  - `\r` (0x0D): ignored.
  - `\n` (0x0A): ends the line.
  - Any other byte: stored at `buf[len]` and `len` increments, when `len < 7`.
  - An 8th non-terminator byte sets `line_bad`; further bytes are dropped until `\n`.
  - A framing error sets `line_bad`.
- On `\n`:
  - `len==0` and `!line_bad`: no pulse.
  - Otherwise, if `!line_bad`, the buffer equals one mode name, and `len` equals its length, then load `mode_code` and pulse `mode_valid`.
  - Any other case pulses `cmd_error`; `mode_code` is unchanged.
  - In every case, `len` and `line_bad` are cleared.
- Matching is exact: no trailing spaces and no prefixes. For example, "GENX" is an error and "GE" is an error.
- `mode_valid` and `cmd_error` are never asserted in the same cycle.

## Timing
- Let t0 be the first cycle in which the synchronised line is low. The physical pin edge is 2 cycles earlier.
- Sample points:
  - start bit at t0 + `BIT_CYCLES/2`;
  - data bit i at t0 + `BIT_CYCLES/2` + (i+1)·`BIT_CYCLES`;
  - stop bit at t0 + `BIT_CYCLES/2` + 9·`BIT_CYCLES`.
- The receiver is back in IDLE on the cycle after the stop sample. A start edge arriving in that cycle is accepted, so back-to-back frames are supported.
- Byte to assembler: registered on the stop-sample cycle.
- `mode_valid`/`cmd_error`: asserted exactly 1 cycle after the stop-sample cycle of `\n`, for exactly 1 cycle. `mode_code` changes in the same cycle as `mode_valid`.
- Reset mid-operation: every register returns to its reset value asynchronously. A partial line is discarded without an error pulse.

## Configuration
- Macro: `MODE_CMD_CASE_FOLD_EN`.
- Defined: bytes 0x61–0x7A are converted to uppercase (minus 0x20) before being stored, so "calc\n" decodes to CALC.
- Undefined: bytes are stored unchanged; lowercase lines do not match and pulse `cmd_error`.

## Test plan
All scenarios use `CLK_FREQ_HZ=1_000_000` and `BAUD_RATE=100_000` (`BIT_CYCLES=10`).

- "SETUP\n" after the guard expires -> `mode_valid` pulses once, 1 cycle after the stop sample of `\n`; `mode_code=5`. Repeat for each name, checking codes 0–4; also send "GEN\r\n" and expect code 2.
- "GENX\n", then "ABCDEFGHIJ\n" -> `cmd_error` pulses once per line; `mode_code` holds its previous value; no `mode_valid`.
- "\n" alone -> neither pulse. Then "SHOW\n" with a zero gap between frames -> `mode_code=3`.
- "CA", then a frame with stop bit = 0, then "LC\n" -> one `cmd_error`. A following "CALC\n" -> `mode_code=4`.
- 3-cycle low glitch on `uart_rx` -> returns to IDLE; no byte delivered. Separately, assert `rst_n` in the middle of "STORE\n", release it while the frame continues, then send "GEN\n" -> no pulse before "GEN\n"; then `mode_code=2`.
- "calc\n" -> `mode_code=4` with `MODE_CMD_CASE_FOLD_EN` defined; `cmd_error` without it.
